// File: rtl/mt9d111_capture_if.sv
// Camera pin bundle plus the rebuilt pixel stream and frame status.
// master = capture block, slave = camera side and pixel consumer.
interface mt9d111_capture_if;
    logic        MT9D111_VSYNC;
    logic        MT9D111_HREF;
    logic [7:0]  MT9D111_D;

    logic        pix_valid;
    logic [15:0] pix_rgb565;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_start;
    logic        frame_end;
    logic        line_err;
    logic        frame_err;
    logic [15:0] frame_cnt;

    modport master (
        input  MT9D111_VSYNC, MT9D111_HREF, MT9D111_D,
        output pix_valid, pix_rgb565, pix_x, pix_y,
               frame_start, frame_end, line_err, frame_err, frame_cnt
    );

    modport slave (
        output MT9D111_VSYNC, MT9D111_HREF, MT9D111_D,
        input  pix_valid, pix_rgb565, pix_x, pix_y,
               frame_start, frame_end, line_err, frame_err, frame_cnt
    );
endinterface

// File: rtl/mt9d111_capture.sv
// MT9D111 byte-stream capture: pairs bytes into RGB565 pixels with x/y tags,
// emits frame markers and checks line length / line count per frame.
module mt9d111_capture #(
    parameter int unsigned H_WIDTH = 160,
    parameter int unsigned V_WIDTH = 128
) (
    input logic               CLOCK65,
    input logic               RESETN,
    mt9d111_capture_if.master cam
);
    localparam int unsigned BYTE_W = 12;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned FCNT_W = 16;
    localparam int unsigned PIX_W  = 16;

    localparam logic [BYTE_W-1:0] LINE_BYTES = BYTE_W'(2 * H_WIDTH);
    localparam logic [CNT_W-1:0]  H_LIM      = CNT_W'(H_WIDTH);
    localparam logic [CNT_W-1:0]  V_LIM      = CNT_W'(V_WIDTH);
    localparam logic [BYTE_W-1:0] BYTE_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic              vs_d, href_d;
    logic              vs_rise, vs_fall, close_line;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_nxt;
    logic [CNT_W-1:0]  x_cnt_q, x_cnt_nxt;
    logic [CNT_W-1:0]  line_cnt_q, line_cnt_nxt;
    logic              phase_q, phase_nxt;
    logic [7:0]        hi_byte_q, hi_byte_nxt;

    logic              pix_valid_q, pix_valid_nxt;
    logic [PIX_W-1:0]  pix_rgb565_q, pix_rgb565_nxt;
    logic [CNT_W-1:0]  pix_x_q, pix_x_nxt;
    logic [CNT_W-1:0]  pix_y_q, pix_y_nxt;
    logic              frame_start_q, frame_start_nxt;
    logic              frame_end_q, frame_end_nxt;
    logic              line_err_q, line_err_nxt;
    logic              frame_err_q, frame_err_nxt;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_nxt;

    assign vs_rise = cam.MT9D111_VSYNC & ~vs_d;
    assign vs_fall = ~cam.MT9D111_VSYNC & vs_d;
    // A VSYNC fall closes an open line even if HREF drops on the same edge.
    assign close_line = href_d & (vs_fall | ~cam.MT9D111_HREF);

    // State register
    always_ff @(posedge CLOCK65) begin
        if (!RESETN) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_SYNC: begin
                if (!cam.MT9D111_VSYNC) begin
                    state_nxt = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (vs_fall) begin
                    state_nxt = ST_WAIT_VS;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        byte_cnt_nxt    = byte_cnt_q;
        x_cnt_nxt       = x_cnt_q;
        line_cnt_nxt    = line_cnt_q;
        phase_nxt       = phase_q;
        hi_byte_nxt     = hi_byte_q;
        pix_valid_nxt   = 1'b0;
        pix_rgb565_nxt  = pix_rgb565_q;
        pix_x_nxt       = pix_x_q;
        pix_y_nxt       = pix_y_q;
        frame_start_nxt = 1'b0;
        frame_end_nxt   = 1'b0;
        line_err_nxt    = 1'b0;
        frame_err_nxt   = 1'b0;
        frame_cnt_nxt   = frame_cnt_q;

        case (state_q)
            ST_WAIT_VS: begin
                if (vs_rise) begin
                    frame_start_nxt = 1'b1;
                    line_cnt_nxt    = '0;
                    x_cnt_nxt       = '0;
                    byte_cnt_nxt    = '0;
                    phase_nxt       = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (close_line) begin
                    line_err_nxt = (byte_cnt_q != LINE_BYTES);
                    line_cnt_nxt = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + 1'b1;
                    x_cnt_nxt    = '0;
                    byte_cnt_nxt = '0;
                    phase_nxt    = 1'b0;
                end else if (!vs_fall && cam.MT9D111_HREF) begin
                    byte_cnt_nxt = (byte_cnt_q == BYTE_MAX) ? byte_cnt_q : byte_cnt_q + 1'b1;
                    phase_nxt    = ~phase_q;
                    if (!phase_q) begin
                        hi_byte_nxt = cam.MT9D111_D;
                    end else begin
                        // Out-of-window bytes still advance x so overlong lines stay aligned.
                        if ((x_cnt_q < H_LIM) && (line_cnt_q < V_LIM)) begin
                            pix_valid_nxt  = 1'b1;
                            pix_rgb565_nxt = {hi_byte_q, cam.MT9D111_D};
                            pix_x_nxt      = x_cnt_q;
                            pix_y_nxt      = line_cnt_q;
                        end
                        x_cnt_nxt = (x_cnt_q == CNT_MAX) ? x_cnt_q : x_cnt_q + 1'b1;
                    end
                end

                if (vs_fall) begin
                    frame_end_nxt = 1'b1;
                    frame_err_nxt = (line_cnt_nxt != V_LIM);
                    frame_cnt_nxt = frame_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath, edge-detect and output registers
    always_ff @(posedge CLOCK65) begin
        if (!RESETN) begin
            vs_d          <= 1'b0;
            href_d        <= 1'b0;
            byte_cnt_q    <= '0;
            x_cnt_q       <= '0;
            line_cnt_q    <= '0;
            phase_q       <= 1'b0;
            hi_byte_q     <= '0;
            pix_valid_q   <= 1'b0;
            pix_rgb565_q  <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            vs_d          <= cam.MT9D111_VSYNC;
            href_d        <= cam.MT9D111_HREF;
            byte_cnt_q    <= byte_cnt_nxt;
            x_cnt_q       <= x_cnt_nxt;
            line_cnt_q    <= line_cnt_nxt;
            phase_q       <= phase_nxt;
            hi_byte_q     <= hi_byte_nxt;
            pix_valid_q   <= pix_valid_nxt;
            pix_rgb565_q  <= pix_rgb565_nxt;
            pix_x_q       <= pix_x_nxt;
            pix_y_q       <= pix_y_nxt;
            frame_start_q <= frame_start_nxt;
            frame_end_q   <= frame_end_nxt;
            line_err_q    <= line_err_nxt;
            frame_err_q   <= frame_err_nxt;
            frame_cnt_q   <= frame_cnt_nxt;
        end
    end

    assign cam.pix_valid   = pix_valid_q;
    assign cam.pix_rgb565  = pix_rgb565_q;
    assign cam.pix_x       = pix_x_q;
    assign cam.pix_y       = pix_y_q;
    assign cam.frame_start = frame_start_q;
    assign cam.frame_end   = frame_end_q;
    assign cam.line_err    = line_err_q;
    assign cam.frame_err   = frame_err_q;
    assign cam.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_mt9d111_capture.sv
// Scoreboard bench for mt9d111_capture: a frame generator pushes expected
// pixels/events with their due cycle; a negedge monitor pops and compares.
module tb_mt9d111_capture;
    localparam int unsigned H  = 16;
    localparam int unsigned V  = 8;
    localparam int unsigned LB = 2 * H;

    logic CLOCK65 = 1'b0;
    logic RESETN;

    mt9d111_capture_if bus();

    mt9d111_capture #(.H_WIDTH(H), .V_WIDTH(V)) dut (
        .CLOCK65 (CLOCK65),
        .RESETN  (RESETN),
        .cam     (bus)
    );

    always #5 CLOCK65 = ~CLOCK65;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] rgb;
        logic [10:0] x;
        logic [10:0] y;
    } pix_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        fs;
        logic        fe;
        logic        le;
        logic        ferr;
        logic [15:0] cnt;
    } ev_t;

    pix_t        pix_q[$];
    ev_t         ev_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          pix_seen = 0;
    logic [15:0] exp_fcnt = 16'd0;
    int          line_len[64];

    always @(posedge CLOCK65) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK65);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_pix(input logic [15:0] rgb, input int x, input int y);
        pix_t p;
        p.cyc = 32'(cyc + 1);
        p.rgb = rgb;
        p.x   = 11'(x);
        p.y   = 11'(y);
        pix_q.push_back(p);
    endtask

    task automatic push_ev(input logic fs, input logic fe, input logic le, input logic ferr,
                           input logic [15:0] cnt);
        ev_t e;
        e.cyc  = 32'(cyc + 1);
        e.fs   = fs;
        e.fe   = fe;
        e.le   = le;
        e.ferr = ferr;
        e.cnt  = cnt;
        ev_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        check({name, ".pix_valid"},   96'(bus.pix_valid),   96'(0));
        check({name, ".pix_rgb565"},  96'(bus.pix_rgb565),  96'(0));
        check({name, ".pix_x"},       96'(bus.pix_x),       96'(0));
        check({name, ".pix_y"},       96'(bus.pix_y),       96'(0));
        check({name, ".frame_start"}, 96'(bus.frame_start), 96'(0));
        check({name, ".frame_end"},   96'(bus.frame_end),   96'(0));
        check({name, ".line_err"},    96'(bus.line_err),    96'(0));
        check({name, ".frame_err"},   96'(bus.frame_err),   96'(0));
        check({name, ".frame_cnt"},   96'(bus.frame_cnt),   96'(0));
    endtask

    task automatic set_lines(input int n);
        for (int l = 0; l < 64; l++) line_len[l] = (l < n) ? int'(LB) : 0;
    endtask

    // Reference: line l carries line_len[l] bytes; pixel i of line l is bytes
    // (2i, 2i+1) and exists only if i < H and l < V. Frame error iff lines != V.
    task automatic drive_frame(input int nlines, input bit pat, input bit simul,
                               input int rst_line, input int rst_pix, input bit live);
        bit         cap;
        logic [7:0] hi;
        logic [7:0] b;
        int         len;
        cap = live;
        hi  = 8'h00;
        tick();
        bus.MT9D111_VSYNC = 1'b1;
        bus.MT9D111_HREF  = 1'b0;
        if (cap) push_ev(1'b1, 1'b0, 1'b0, 1'b0, exp_fcnt);
        idle(1 + int'($urandom_range(0, 2)));
        for (int l = 0; l < nlines; l++) begin
            len = line_len[l];
            for (int i = 0; i < len; i++) begin
                if (cap && l == rst_line && i == 2 * rst_pix) begin
                    tick();
                    RESETN = 1'b0;
                    tick();
                    RESETN = 1'b1;
                    check_idle("rst_mid");
                    check("rst_mid.pix_q", 96'(pix_q.size()), 96'(0));
                    check("rst_mid.ev_q",  96'(ev_q.size()),  96'(0));
                    cap      = 1'b0;
                    exp_fcnt = 16'd0;
                end
                tick();
                bus.MT9D111_HREF = 1'b1;
                b = pat ? ((i % 2 == 0) ? 8'(l) : 8'(i / 2)) : 8'($urandom);
                bus.MT9D111_D = b;
                if (i % 2 == 0) hi = b;
                else if (cap && (i / 2) < int'(H) && l < int'(V)) push_pix({hi, b}, i / 2, l);
            end
            if (l == nlines - 1 && simul) begin
                tick();
                bus.MT9D111_HREF  = 1'b0;
                bus.MT9D111_VSYNC = 1'b0;
                if (cap) begin
                    push_ev(1'b0, 1'b1, len != int'(LB), nlines != int'(V), exp_fcnt + 16'd1);
                    exp_fcnt = exp_fcnt + 16'd1;
                end
            end else begin
                tick();
                bus.MT9D111_HREF = 1'b0;
                if (cap && len != int'(LB)) push_ev(1'b0, 1'b0, 1'b1, 1'b0, exp_fcnt);
                idle(int'($urandom_range(1, 3)));
            end
        end
        if (!simul) begin
            tick();
            bus.MT9D111_VSYNC = 1'b0;
            if (cap) begin
                push_ev(1'b0, 1'b1, 1'b0, nlines != int'(V), exp_fcnt + 16'd1);
                exp_fcnt = exp_fcnt + 16'd1;
            end
        end
        idle(3);
    endtask

    // Inter-frame gap with a stray HREF pulse that must be ignored.
    task automatic drain(input string name);
        idle(2);
        tick();
        bus.MT9D111_HREF = 1'b1;
        bus.MT9D111_D    = 8'($urandom);
        tick();
        bus.MT9D111_HREF = 1'b0;
        idle(4);
        check({name, ".pix_left"}, 96'(pix_q.size()), 96'(0));
        check({name, ".ev_left"},  96'(ev_q.size()),  96'(0));
    endtask

    // Monitor
    logic prev_pv = 1'b0;
    always @(negedge CLOCK65) begin
        pix_t gp, ep;
        ev_t  ge, ee;
        if (bus.pix_valid === 1'b1) begin
            pix_seen++;
            check("pix_rate", 96'(prev_pv), 96'(0));
            gp.cyc = 32'(cyc);
            gp.rgb = bus.pix_rgb565;
            gp.x   = bus.pix_x;
            gp.y   = bus.pix_y;
            if (pix_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pix_extra actual=%h required=none", gp);
            end else begin
                ep = pix_q.pop_front();
                check("pix", 96'(gp), 96'(ep));
            end
        end
        prev_pv = (bus.pix_valid === 1'b1);
        if ((bus.frame_start | bus.frame_end | bus.line_err | bus.frame_err) === 1'b1) begin
            ge.cyc  = 32'(cyc);
            ge.fs   = bus.frame_start;
            ge.fe   = bus.frame_end;
            ge.le   = bus.line_err;
            ge.ferr = bus.frame_err;
            ge.cnt  = bus.frame_cnt;
            if (ev_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ev_extra actual=%h required=none", ge);
            end else begin
                ee = ev_q.pop_front();
                check("event", 96'(ge), 96'(ee));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=%0d required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int n;
        RESETN            = 1'b0;
        bus.MT9D111_VSYNC = 1'b0;
        bus.MT9D111_HREF  = 1'b0;
        bus.MT9D111_D     = 8'h00;
        idle(4);
        check_idle("reset");
        tick();
        RESETN = 1'b1;
        idle(3);

        // Nominal frame, bytes high=y low=x
        set_lines(V);
        p0 = pix_seen;
        drive_frame(V, 1'b1, 1'b0, -1, -1, 1'b1);
        drain("nominal");
        check("nominal.count", 96'(pix_seen - p0), 96'(H * V));

        // Short line 5
        set_lines(V);
        line_len[5] = LB - 2;
        drive_frame(V, 1'b0, 1'b0, -1, -1, 1'b1);
        drain("short_line");

        // Long odd line
        set_lines(V);
        line_len[2] = LB + 1;
        drive_frame(V, 1'b0, 1'b0, -1, -1, 1'b1);
        drain("long_line");

        // Too many lines: extra lines produce no pixels
        set_lines(V + 2);
        p0 = pix_seen;
        drive_frame(V + 2, 1'b1, 1'b0, -1, -1, 1'b1);
        drain("tall_frame");
        check("tall.count", 96'(pix_seen - p0), 96'(H * V));

        // Too few lines, odd short last line closed by simultaneous VSYNC fall
        set_lines(V - 1);
        line_len[0]     = 7;
        line_len[V - 2] = LB - 3;
        drive_frame(V - 1, 1'b0, 1'b1, -1, -1, 1'b1);
        drain("simul_end");

        // Reset released while VSYNC high: rest of that frame ignored
        tick();
        RESETN            = 1'b0;
        bus.MT9D111_VSYNC = 1'b1;
        idle(2);
        tick();
        RESETN   = 1'b1;
        exp_fcnt = 16'd0;
        check_idle("rst_vs_high");
        set_lines(V);
        drive_frame(V, 1'b0, 1'b0, -1, -1, 1'b0);
        drain("ignored_frame");
        set_lines(V);
        drive_frame(V, 1'b1, 1'b0, -1, -1, 1'b1);
        drain("after_vs_reset");

        // Reset pulse mid-line aborts the frame
        set_lines(V);
        drive_frame(V, 1'b0, 1'b0, 3, 5, 1'b1);
        drain("aborted_frame");
        set_lines(V);
        drive_frame(V, 1'b0, 1'b0, -1, -1, 1'b1);
        drain("after_mid_reset");

        // Randomised frames
        for (int f = 0; f < 10; f++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(V - 1, V + 2)) : int'(V);
            set_lines(n);
            for (int l = 0; l < n; l++)
                if ($urandom_range(0, 3) == 0) line_len[l] = int'($urandom_range(LB - 3, LB + 3));
            drive_frame(n, 1'b0, 1'($urandom_range(0, 1)), -1, -1, 1'b1);
            drain("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
